// File: rtl/count_pkg.sv
// Shared definitions for the modulo-15 counter and its verification environment.
package count_pkg;

  localparam int CNT_WIDTH = 4;
  localparam int CNT_MOD   = 15;
  localparam int CNT_MAX   = CNT_MOD - 1;

  localparam int number_of_transactions = 500;

  typedef logic [CNT_WIDTH-1:0] count_t;

  typedef enum logic {
    DOWN = 1'b0,
    UP   = 1'b1
  } mode_e;

endpackage

// File: rtl/mod15_next_state.sv
// Pure combinational next-count function: load, else step up/down with wrap at MODULUS-1.
module mod15_next_state
  import count_pkg::*;
#(
  parameter int WIDTH   = CNT_WIDTH,
  parameter int MODULUS = CNT_MOD
) (
  input  logic [WIDTH-1:0] cur,
  input  logic             mode,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] next
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

  // Wrap uses explicit compares so MODULUS below 2**WIDTH never relies on overflow.
  always_comb begin
    next = '0;
    if (load) begin
      next = (data <= MAX_VAL) ? data : '0;
    end else if (mode_e'(mode) == UP) begin
      next = (cur >= MAX_VAL) ? '0 : cur + WIDTH'(1);
    end else begin
      next = (cur == '0) ? MAX_VAL : cur - WIDTH'(1);
    end
  end

endmodule

// File: rtl/mod15_counter.sv
// Modulo-15 up/down counter with parallel load; sync active-high reset, registered output.
module mod15_counter
  import count_pkg::*;
#(
  parameter int WIDTH   = CNT_WIDTH,
  parameter int MODULUS = CNT_MOD
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] data_out
);

  logic [WIDTH-1:0] next_count;

  mod15_next_state #(
    .WIDTH  (WIDTH),
    .MODULUS(MODULUS)
  ) u_next (
    .cur (data_out),
    .mode(mode),
    .load(load),
    .data(data),
    .next(next_count)
  );

  // Reset takes priority over both load and count in the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out <= '0;
    end else begin
      data_out <= next_count;
    end
  end

endmodule

// File: tb/tb_mod15_counter.sv
// Self-checking bench for mod15_counter: directed scenarios plus randomized regression vs. modular-arithmetic model.
module tb_mod15_counter;
  import count_pkg::*;

  logic         clk;
  logic         rst;
  logic         mode;
  logic         load;
  logic [3:0]   data;
  logic [3:0]   data_out;

  int checks;
  int errors;

  logic [3:0] exp_q[$];

  mod15_counter #(
    .WIDTH  (CNT_WIDTH),
    .MODULUS(CNT_MOD)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .mode    (mode),
    .load    (load),
    .data    (data),
    .data_out(data_out)
  );

  // Clock / reset defaults
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: counting is arithmetic modulo CNT_MOD.
  function automatic int model_next(int cur, bit r, bit l, bit m, int d);
    if (r) return 0;
    if (l) return (d < CNT_MOD) ? d : 0;
    if (m) return (cur + 1) % CNT_MOD;
    return (cur + CNT_MOD - 1) % CNT_MOD;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(bit r, bit l, bit m, logic [3:0] d);
    rst  = r;
    load = l;
    mode = m;
    data = d;
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b1, UP, 4'd9);
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (data_out !== 4'd0) begin
        errors++;
        $display("FAIL reset cycle %0d: data_out=%0d expected=0", i, data_out);
      end
    end
  endtask

  task automatic test_up_wrap();
    int exp_seq[5] = '{12, 13, 14, 0, 1};
    drive(1'b0, 1'b1, UP, 4'd12);
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (data_out !== 4'(exp_seq[i])) begin
        errors++;
        $display("FAIL up_wrap step %0d: data_out=%0d expected=%0d", i, data_out, exp_seq[i]);
      end
      drive(1'b0, 1'b0, UP, 4'($urandom_range(0, 15)));
    end
  endtask

  task automatic test_down_wrap();
    int exp_seq[5] = '{1, 0, 14, 13, 12};
    drive(1'b0, 1'b1, DOWN, 4'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (data_out !== 4'(exp_seq[i])) begin
        errors++;
        $display("FAIL down_wrap step %0d: data_out=%0d expected=%0d", i, data_out, exp_seq[i]);
      end
      drive(1'b0, 1'b0, DOWN, 4'($urandom_range(0, 15)));
    end
  endtask

  task automatic test_load_priority();
    drive(1'b0, 1'b1, DOWN, 4'd4);
    tick();
    drive(1'b0, 1'b0, UP, 4'd0);
    tick();
    checks++;
    if (data_out !== 4'd5) begin
      errors++;
      $display("FAIL load_setup: data_out=%0d expected=5", data_out);
    end
    drive(1'b0, 1'b1, UP, 4'd15);
    tick();
    checks++;
    if (data_out !== 4'd0) begin
      errors++;
      $display("FAIL load_out_of_range: data_out=%0d expected=0", data_out);
    end
    drive(1'b0, 1'b1, DOWN, 4'd7);
    tick();
    checks++;
    if (data_out !== 4'd7) begin
      errors++;
      $display("FAIL load_ignores_mode: data_out=%0d expected=7", data_out);
    end
    drive(1'b1, 1'b1, UP, 4'd11);
    tick();
    checks++;
    if (data_out !== 4'd0) begin
      errors++;
      $display("FAIL reset_over_load: data_out=%0d expected=0", data_out);
    end
  endtask

  task automatic test_direction_switch();
    int exp_seq[5] = '{4, 5, 4, 3, 2};
    bit dir_seq[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    drive(1'b0, 1'b1, DOWN, 4'd3);
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, dir_seq[i], 4'd0);
      tick();
      checks++;
      if (data_out !== 4'(exp_seq[i])) begin
        errors++;
        $display("FAIL dir_switch step %0d: data_out=%0d expected=%0d", i, data_out, exp_seq[i]);
      end
    end
  endtask

  task automatic test_random();
    int model_val;
    bit r, l, m;
    int d;
    logic [3:0] exp_val;
    drive(1'b1, 1'b0, UP, 4'd0);
    tick();
    model_val = 0;
    for (int i = 0; i < number_of_transactions; i++) begin
      r = ($urandom_range(0, 99) < 5);
      l = ($urandom_range(0, 99) < 20);
      m = 1'($urandom_range(0, 1));
      d = $urandom_range(0, 15);
      drive(r, l, m, 4'(d));
      model_val = model_next(model_val, r, l, m, d);
      exp_q.push_back(4'(model_val));
      tick();
      exp_val = exp_q.pop_front();
      checks++;
      if (data_out !== exp_val) begin
        errors++;
        $display("FAIL random txn %0d: data_out=%0d expected=%0d (rst=%0b load=%0b mode=%0b data=%0d)",
                 i, data_out, exp_val, r, l, m, d);
      end
      checks++;
      if (!(data_out <= 4'(CNT_MAX))) begin
        errors++;
        $display("FAIL random range %0d: data_out=%0d expected<=%0d", i, data_out, CNT_MAX);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    drive(1'b1, 1'b0, UP, 4'd0);
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_load_priority();
    test_direction_switch();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
